// File: rtl/platform_button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : platform_button_ctrl
//  Description : Avalon-MM push-button controller. Synchronises and debounces
//                active-low button lines, latches press events (debounced
//                1->0) in a W1C edge-capture register and raises a maskable
//                level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module platform_button_ctrl #(
  parameter int WIDTH       = 2,
  parameter int CNT_W       = 20,
  parameter int DEB_DEFAULT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] C_PERIOD_RST = CNT_W'(DEB_DEFAULT);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] eff_m1;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      rd_d;
  logic [31:0]      readdata_q;
  logic             irq_q;
  logic             wr_mask, wr_edge, wr_period;
  logic             unused_wdata;

  // Only the low bits of writedata land in registers; the rest is don't-care.
  assign unused_wdata = ^writedata;

  assign wr_mask   = write && (address == 2'd1);
  assign wr_edge   = write && (address == 2'd2);
  assign wr_period = write && (address == 2'd3);

  // Commit threshold: a period of zero behaves as a period of one.
  assign eff_m1 = (period_q == '0) ? '0 : (period_q - CNT_W'(1));

  // Two-flop synchroniser for the asynchronous button lines (released = 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count while the synchronised level differs from the
  // debounced level, commit once the difference has lasted the full period.
  // The counter never passes eff_m1 because reaching it commits.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] >= eff_m1) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Press = debounced falling edge; a same-cycle W1C loses against a press.
  assign w_press   = deb_q & ~deb_d;
  assign w_clr     = wr_edge ? writedata[WIDTH-1:0] : '0;
  assign edgecap_d = (edgecap_q & ~w_clr) | w_press;

  // Software-visible control registers and edge capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
      period_q  <= C_PERIOD_RST;
    end else begin
      edgecap_q <= edgecap_d;
      if (wr_mask) begin
        irqmask_q <= writedata[WIDTH-1:0];
      end
      if (wr_period) begin
        period_q <= writedata[CNT_W-1:0];
      end
    end
  end

  // Read mux uses pre-write register values; zero-extended to 32 bits.
  always_comb begin
    rd_d = '0;
    case (address)
      2'd0:    rd_d[WIDTH-1:0] = deb_q;
      2'd1:    rd_d[WIDTH-1:0] = irqmask_q;
      2'd2:    rd_d[WIDTH-1:0] = edgecap_q;
      default: rd_d[CNT_W-1:0] = period_q;
    endcase
  end

  // Registered read data and interrupt; irq sees no bus inputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (read) begin
        readdata_q <= rd_d;
      end
      irq_q <= |(edgecap_q & irqmask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_platform_button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_platform_button_ctrl
//  Description : Scoreboard bench for platform_button_ctrl. A behavioural
//                model predicts read data and irq; a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_platform_button_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] in_port;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd_q  [$];
  logic        irq_q [$];

  // Model state: debounced level judged from the history of synchronised
  // samples (a change commits once it has persisted for the whole period).
  logic [W-1:0] m_deb, m_ec, m_mask, m_p1, m_p2;
  logic [19:0]  m_period;
  logic [W-1:0] hist [$];

  platform_button_ctrl #(.WIDTH(2), .CNT_W(20), .DEB_DEFAULT(50000)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_deb};
      2'd1:    return {30'd0, m_mask};
      2'd2:    return {30'd0, m_ec};
      default: return {12'd0, m_period};
    endcase
  endfunction

  task automatic model_reset();
    m_deb = '1; m_ec = '0; m_mask = '0; m_period = 20'd50000;
    m_p1 = '1; m_p2 = '1;
    hist.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] s, nd, press, clr;
    int eff, run;
    s = m_p2; m_p2 = m_p1; m_p1 = in_port;
    if (read) rd_q.push_back(reg_rd(address));
    hist.push_back(s);
    if (hist.size() > 64) void'(hist.pop_front());
    eff = (m_period == 0) ? 1 : int'(m_period);
    nd = m_deb;
    for (int i = 0; i < W; i++) begin
      run = 0;
      for (int k = hist.size() - 1; k >= 0; k--) begin
        if (hist[k][i] != m_deb[i]) run++;
        else break;
      end
      if (run >= eff) nd[i] = s[i];
    end
    press = m_deb & ~nd;
    clr = (write && address == 2'd2) ? writedata[W-1:0] : '0;
    irq_q.push_back(|(m_ec & m_mask));
    m_ec = (m_ec & ~clr) | press;
    if (write && address == 2'd1) m_mask = writedata[W-1:0];
    if (write && address == 2'd3) m_period = writedata[19:0];
    m_deb = nd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: readdata is valid the cycle after a read; irq every cycle.
  initial begin : monitor
    logic fire;
    forever begin
      @(posedge clk);
      fire = read && !reset;
      @(negedge clk);
      if (!reset) begin
        if (fire) begin
          if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
          else check("readdata", readdata, rd_q.pop_front());
        end
        if (irq_q.size() > 0) check("irq", {31'd0, irq}, {31'd0, irq_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_rd(input logic [1:0] a);
    read = 1'b1; address = a; tick();
  endtask

  task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
    write = 1'b1; address = a; writedata = d; tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : stim
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    in_port = '1;
    model_reset();
    #2;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset values through the bus.
    for (int a = 0; a < 4; a++) do_rd(2'(a));
    idle(1);

    // Clean press on bit 0, exact commit latency observed by polling.
    do_wr(2'd3, 32'd4);
    do_wr(2'd1, 32'd1);
    in_port = 2'b10;
    for (int j = 0; j < 8; j++) do_rd(2'd0);
    do_rd(2'd2);
    idle(2);

    // Short glitches on bit 1 never commit.
    for (int r = 0; r < 3; r++) begin
      in_port[1] = 1'b0;
      for (int j = 0; j < 3; j++) do_rd(2'd0);
      in_port[1] = 1'b1;
      for (int j = 0; j < 3; j++) do_rd(2'd2);
    end

    // W1C clears the capture and drops irq.
    do_wr(2'd2, 32'd1);
    idle(2);
    do_rd(2'd2);
    // Release, then press again with the W1C landing on the press cycle.
    in_port = 2'b11;
    idle(10);
    in_port = 2'b10;
    for (int j = 1; j <= 8; j++) begin
      if (j == 6) begin write = 1'b1; address = 2'd2; writedata = 32'd1; end
      tick();
    end
    do_rd(2'd2);
    idle(2);

    // Period 0 behaves as period 1; oversized period write truncates.
    do_wr(2'd3, 32'd0);
    in_port = 2'b00;
    for (int j = 0; j < 5; j++) do_rd(2'd0);
    in_port = 2'b11;
    for (int j = 0; j < 5; j++) do_rd(2'd0);
    do_wr(2'd3, 32'hFFFF_FFFF);
    do_rd(2'd3);

    // Reset while bit 0 is mid-debounce.
    do_wr(2'd3, 32'd4);
    do_wr(2'd2, 32'h3);
    idle(8);
    in_port = 2'b10;
    idle(4);
    @(negedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_readdata", readdata, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) do_rd(2'(a));
    do_wr(2'd3, 32'd4);
    do_wr(2'd1, 32'd3);
    for (int j = 0; j < 6; j++) do_rd(2'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 11) == 0) in_port[i] = ~in_port[i];
      if ($urandom_range(0, 2) == 0) read = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        write = 1'b1;
        writedata = $urandom;
      end
      address = 2'($urandom_range(0, 3));
      if (write && address == 2'd3) writedata = $urandom_range(0, 8);
      tick();
    end

    idle(3);
    check("rd_queue_drained", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
